// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display: FSM states, digit count,
// and active-low seven-segment patterns in {g,f,e,d,c,b,a} order.
package score_display_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  localparam int NUM_DIGITS = 5;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam int BIN_W      = 16;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD nibble to active-low seven-segment pattern.
// Nibbles above 9 produce a blank digit.
module seg7_encode
  import score_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// Score to five-digit seven-segment display (shift-add-3 BCD engine) plus hit
// acknowledge and retriggerable LED flash. Optional macro: LEADING_ZERO_BLANK_EN.
module score_display
  import score_display_pkg::*;
#(
  parameter int FLASH_CYCLES = 25000000,
  parameter int CNT_W        = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] score,
  input  logic             hit_req,
  output logic             note_hit,
  output logic             hit_led,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3,
  output logic [6:0]       hex4,
  output logic             bcd_valid
);

  state_t             state, state_nxt;
  logic               first_cyc, start, capture, shift_en, load_en;
  logic [BIN_W-1:0]   last_score, bin_sr;
  logic [BCD_W-1:0]   bcd, bcd_adj;
  logic [4:0]         bit_cnt;
  logic [3:0]         nib_disp [NUM_DIGITS];
  logic [6:0]         seg_enc  [NUM_DIGITS];
  logic [6:0]         hex_q    [NUM_DIGITS];
  logic               hit_req_d;
  logic [CNT_W-1:0]   flash_cnt;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  assign start   = first_cyc || (score != last_score);
  assign bcd_adj = add3(bcd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == 5'd1) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    capture  = (state == IDLE) && start;
    shift_en = (state == SHIFT);
    load_en  = (state == LOAD);
  end

  // Conversion datapath: capture, one shift-add-3 step per cycle, then load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_cyc  <= 1'b1;
      last_score <= '0;
      bin_sr     <= '0;
      bcd        <= '0;
      bit_cnt    <= '0;
      bcd_valid  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= SEG_0;
    end else begin
      first_cyc <= 1'b0;
      if (capture) begin
        bin_sr     <= score;
        last_score <= score;
        bcd        <= '0;
        bit_cnt    <= 5'd16;
        bcd_valid  <= 1'b0;
      end
      if (shift_en) begin
        bcd     <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
        bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
        bit_cnt <= bit_cnt - 5'd1;
      end
      if (load_en) begin
        for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= seg_enc[i];
        bcd_valid <= 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lead_zero;
  // Nibble 4'hF encodes to blank; the ones digit is never blanked.
  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_DIGITS-1] = (bcd[BCD_W-1 -: 4] == 4'd0);
    for (int i = NUM_DIGITS-2; i >= 1; i--)
      lead_zero[i] = lead_zero[i+1] && (bcd[4*i +: 4] == 4'd0);
    for (int i = 0; i < NUM_DIGITS; i++)
      nib_disp[i] = lead_zero[i] ? 4'hF : bcd[4*i +: 4];
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) nib_disp[i] = bcd[4*i +: 4];
  end
`endif

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
    seg7_encode u_enc (
      .nib (nib_disp[g]),
      .seg (seg_enc[g])
    );
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];

  // Hit handshake: rising-edge acknowledge and retriggerable flash counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_req_d <= 1'b0;
      note_hit  <= 1'b0;
      flash_cnt <= '0;
    end else begin
      hit_req_d <= hit_req;
      note_hit  <= hit_req && !hit_req_d;
      if (hit_req && !hit_req_d)  flash_cnt <= CNT_W'(FLASH_CYCLES);
      else if (flash_cnt != '0)   flash_cnt <= flash_cnt - 1'b1;
    end
  end

  assign hit_led = (flash_cnt != '0);

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: randomized scores and hit patterns
// checked against a decimal/event-level reference model.
module tb_score_display;

  localparam int FLASH = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] score;
  logic        hit_req;
  logic        note_hit, hit_led, bcd_valid;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4;
  logic [6:0]  hex_dut [5];

  int n_checks = 0;
  int n_errors = 0;
  int shown = 0;
  bit after_reset = 1'b1;

  assign hex_dut[0] = hex0;
  assign hex_dut[1] = hex1;
  assign hex_dut[2] = hex2;
  assign hex_dut[3] = hex3;
  assign hex_dut[4] = hex4;

  score_display #(.FLASH_CYCLES(FLASH), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .score(score), .hit_req(hit_req),
    .note_hit(note_hit), .hit_led(hit_led),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4),
    .bcd_valid(bcd_valid)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] exp_seg(input int s, input int i);
    int p;
    int d;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    d = (s / p) % 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && s < p) return 7'h7F;
`endif
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] held_seg(input int i);
    if (after_reset) return 7'h40;
    return exp_seg(shown, i);
  endfunction

  task automatic convert_check(input int s, input string name);
    score = s[15:0];
    for (int k = 1; k <= 17; k++) begin
      tick;
      n_checks++;
      if (bcd_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL %s busy_valid cyc=%0d got=%b want=0", name, k, bcd_valid);
      end
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (hex_dut[i] !== held_seg(i)) begin
          n_errors++;
          $display("FAIL %s hold_hex%0d cyc=%0d got=%h want=%h", name, i, k, hex_dut[i], held_seg(i));
        end
      end
    end
    tick;
    n_checks++;
    if (bcd_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL %s done_valid got=%b want=1", name, bcd_valid);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (hex_dut[i] !== exp_seg(s, i)) begin
        n_errors++;
        $display("FAIL %s hex%0d score=%0d got=%h want=%h", name, i, s, hex_dut[i], exp_seg(s, i));
      end
    end
    shown = s;
    after_reset = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; score = 16'd0; hit_req = 1'b0;
    #2;
    n_checks++;
    if (note_hit !== 1'b0 || hit_led !== 1'b0 || bcd_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl got=%b%b%b want=000", note_hit, hit_led, bcd_valid);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (hex_dut[i] !== 7'h40) begin
        n_errors++;
        $display("FAIL reset_hex%0d got=%h want=40", i, hex_dut[i]);
      end
    end
    tick; tick;
    rst = 1'b0;
    after_reset = 1'b1;
    convert_check(0, "first_after_reset");
  endtask

  task automatic test_conversions;
    convert_check(12345, "score_12345");
    convert_check(65535, "score_max");
    convert_check(9, "score_9");
  endtask

  task automatic test_midchange;
    int cyc;
    score = 16'd100;
    cyc = 0;
    for (int k = 0; k < 5; k++) begin tick; cyc++; end
    score = 16'd200;
    while (bcd_valid !== 1'b1 && cyc < 40) begin tick; cyc++; end
    n_checks++;
    if (cyc != 18) begin
      n_errors++;
      $display("FAIL mid_first_latency got=%0d want=18", cyc);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (hex_dut[i] !== exp_seg(100, i)) begin
        n_errors++;
        $display("FAIL mid_first_hex%0d got=%h want=%h", i, hex_dut[i], exp_seg(100, i));
      end
    end
    while (bcd_valid === 1'b1 && cyc < 60) begin tick; cyc++; end
    while (bcd_valid !== 1'b1 && cyc < 80) begin tick; cyc++; end
    n_checks++;
    if (cyc - 1 > 36 || bcd_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_settle got=%0d cycles want<=36", cyc - 1);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (hex_dut[i] !== exp_seg(200, i)) begin
        n_errors++;
        $display("FAIL mid_second_hex%0d got=%h want=%h", i, hex_dut[i], exp_seg(200, i));
      end
    end
    shown = 200;
  endtask

  task automatic test_random_scores;
    int s;
    for (int n = 0; n < 6; n++) begin
      s = (n == 2) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 65535));
      if (s == shown) s = s ^ 1;
      convert_check(s, "random_score");
    end
  endtask

  task automatic test_hit_single;
    hit_req = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick;
      n_checks++;
      if (note_hit !== (k == 0) || hit_led !== (k < FLASH)) begin
        n_errors++;
        $display("FAIL hit_single k=%0d got note=%b led=%b want note=%b led=%b",
                 k, note_hit, hit_led, (k == 0), (k < FLASH));
      end
    end
    hit_req = 1'b0;
    tick;
  endtask

  task automatic test_hit_retrigger;
    score = 16'd777;
    hit_req = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      tick;
      n_checks++;
      if (note_hit !== (k == 0 || k == 4) || hit_led !== (k < 4 + FLASH)) begin
        n_errors++;
        $display("FAIL hit_retrig k=%0d got note=%b led=%b want note=%b led=%b",
                 k, note_hit, hit_led, (k == 0 || k == 4), (k < 4 + FLASH));
      end
      if (k == 1) hit_req = 1'b0;
      if (k == 3) hit_req = 1'b1;
    end
    hit_req = 1'b0;
    n_checks++;
    if (bcd_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL hit_parallel_valid got=%b want=1", bcd_valid);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (hex_dut[i] !== exp_seg(777, i)) begin
        n_errors++;
        $display("FAIL hit_parallel_hex%0d got=%h want=%h", i, hex_dut[i], exp_seg(777, i));
      end
    end
    shown = 777;
    tick;
  endtask

  task automatic test_random_hits;
    bit prev_req;
    bit ack;
    int since;
    prev_req = hit_req;
    since = 1000;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) hit_req = ~hit_req;
      tick;
      ack = hit_req && !prev_req;
      prev_req = hit_req;
      if (ack) since = 0;
      else if (since < 1000) since++;
      n_checks++;
      if (note_hit !== ack || hit_led !== (since < FLASH)) begin
        n_errors++;
        $display("FAIL hit_random n=%0d got note=%b led=%b want note=%b led=%b",
                 n, note_hit, hit_led, ack, (since < FLASH));
      end
    end
    hit_req = 1'b0;
    for (int k = 0; k < FLASH + 2; k++) tick;
  endtask

  task automatic test_async_reset;
    int cyc;
    score = 16'd54321;
    hit_req = 1'b1;
    for (int k = 0; k < 5; k++) tick;
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (note_hit !== 1'b0 || hit_led !== 1'b0 || bcd_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL async_rst_ctrl got=%b%b%b want=000", note_hit, hit_led, bcd_valid);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (hex_dut[i] !== 7'h40) begin
        n_errors++;
        $display("FAIL async_rst_hex%0d got=%h want=40", i, hex_dut[i]);
      end
    end
    tick;
    rst = 1'b0;
    tick;
    n_checks++;
    if (note_hit !== 1'b1 || hit_led !== 1'b1) begin
      n_errors++;
      $display("FAIL hit_out_of_reset got note=%b led=%b want 1 1", note_hit, hit_led);
    end
    cyc = 1;
    while (bcd_valid !== 1'b1 && cyc < 40) begin tick; cyc++; end
    n_checks++;
    if (cyc != 18) begin
      n_errors++;
      $display("FAIL post_rst_latency got=%0d want=18", cyc);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (hex_dut[i] !== exp_seg(54321, i)) begin
        n_errors++;
        $display("FAIL post_rst_hex%0d got=%h want=%h", i, hex_dut[i], exp_seg(54321, i));
      end
    end
    hit_req = 1'b0;
  endtask

  initial begin
    test_reset;
    test_conversions;
    test_midchange;
    test_random_scores;
    test_hit_single;
    test_hit_retrigger;
    test_random_hits;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
